// File: rtl/mmio_req_pkg.sv
// rtl/mmio_req_pkg.sv - shared types and widths for the MMIO requester
package mmio_req_pkg;

   localparam int MMIO_ADDR_W = 16;
   localparam int MMIO_TID_W  = 9;
   localparam int MMIO_DATA_W = 64;

   typedef logic [MMIO_ADDR_W-1:0] t_mmio_addr;
   typedef logic [MMIO_TID_W-1:0]  t_mmio_tid;
   typedef logic [MMIO_DATA_W-1:0] t_mmio_data;

   localparam logic [15:0] STRAY_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } t_mreq_state;

endpackage

// File: rtl/mmio_requester.sv
// rtl/mmio_requester.sv - single-outstanding MMIO read/write initiator toward an AFU
// Issues one request per command, matches the read response by TID, times out stalled reads.
module mmio_requester
   import mmio_req_pkg::*;
#(
   parameter int TIMEOUT = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [63:0] cmd_wdata,
   output logic        mmio_wr_valid,
   output logic        mmio_rd_valid,
   output logic [15:0] mmio_addr,
   output logic [8:0]  mmio_tid,
   output logic [63:0] mmio_data,
   input  logic        rsp_valid,
   input  logic [8:0]  rsp_tid,
   input  logic [63:0] rsp_data,
   output logic        res_valid,
   output logic [63:0] res_data,
   output logic        res_err,
   output logic [15:0] stray_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   // Decided one cycle early so the registered result lands TIMEOUT cycles after ISSUE.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 2);

   t_mreq_state      state_q, state_d;
   t_mmio_tid        tid_q, tid_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             wr_valid_q, wr_valid_d;
   logic             rd_valid_q, rd_valid_d;
   t_mmio_addr       addr_q, addr_d;
   t_mmio_tid        mtid_q, mtid_d;
   t_mmio_data       mdata_q, mdata_d;
   logic             res_valid_q, res_valid_d;
   t_mmio_data       res_data_q, res_data_d;
   logic             res_err_q, res_err_d;
   logic [15:0]      stray_q, stray_d;

   logic accept, rsp_match, timed_out;

   assign accept    = (state_q == IDLE) && cmd_valid;
   assign rsp_match = (state_q == WAIT_RSP) && rsp_valid && (rsp_tid == mtid_q);
   assign timed_out = (state_q == WAIT_RSP) && (timer_q == TMR_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cmd_valid) state_d = ISSUE;
         ISSUE:    state_d = wr_valid_q ? IDLE : WAIT_RSP;
         WAIT_RSP: if (rsp_match || timed_out) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      tid_d       = tid_q;
      timer_d     = timer_q;
      addr_d      = addr_q;
      mtid_d      = mtid_q;
      mdata_d     = mdata_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      stray_d     = stray_q;
      cmd_ready_d = (state_d == IDLE);
      wr_valid_d  = accept && cmd_write;
      rd_valid_d  = accept && !cmd_write;

      if (accept) begin
         addr_d  = cmd_addr;
         mtid_d  = tid_q;
         mdata_d = cmd_write ? cmd_wdata : '0;
      end
      // Only reads consume a TID; writes are posted.
      if ((state_q == ISSUE) && rd_valid_q) begin
         tid_d   = tid_q + 1'b1;
         timer_d = '0;
      end
      if (state_q == WAIT_RSP) begin
         timer_d = timer_q + 1'b1;
         if (rsp_match) begin
            res_valid_d = 1'b1;
            res_data_d  = rsp_data;
            res_err_d   = 1'b0;
         end else if (timed_out) begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b1;
         end
      end
      if (rsp_valid && !rsp_match && (stray_q != STRAY_MAX)) stray_d = stray_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tid_q       <= '0;
         timer_q     <= '0;
         cmd_ready_q <= 1'b1;
         wr_valid_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         addr_q      <= '0;
         mtid_q      <= '0;
         mdata_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         stray_q     <= '0;
      end else begin
         tid_q       <= tid_d;
         timer_q     <= timer_d;
         cmd_ready_q <= cmd_ready_d;
         wr_valid_q  <= wr_valid_d;
         rd_valid_q  <= rd_valid_d;
         addr_q      <= addr_d;
         mtid_q      <= mtid_d;
         mdata_q     <= mdata_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         stray_q     <= stray_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign mmio_wr_valid = wr_valid_q;
   assign mmio_rd_valid = rd_valid_q;
   assign mmio_addr     = addr_q;
   assign mmio_tid      = mtid_q;
   assign mmio_data     = mdata_q;
   assign res_valid     = res_valid_q;
   assign res_data      = res_data_q;
   assign res_err       = res_err_q;
   assign stray_cnt     = stray_q;

endmodule

// File: tb/tb_mmio_requester.sv
// tb/tb_mmio_requester.sv - randomized bench for mmio_requester against a cycle-scheduled model
module tb_mmio_requester;
   import mmio_req_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [63:0] cmd_wdata = '0;
   logic        rsp_valid = 1'b0;
   logic [8:0]  rsp_tid = '0;
   logic [63:0] rsp_data = '0;
   logic        cmd_ready, mmio_wr_valid, mmio_rd_valid, res_valid, res_err;
   logic [15:0] mmio_addr, stray_cnt;
   logic [8:0]  mmio_tid;
   logic [63:0] mmio_data, res_data;

   mmio_requester #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
      .stray_cnt(stray_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Expected behaviour, keyed by absolute cycle number.
   bit          e_busy[int];
   bit          e_wr[int];
   bit          e_rd[int];
   logic [15:0] e_addr[int];
   logic [8:0]  e_tid[int];
   logic [63:0] e_mdata[int];
   bit          e_res[int];
   logic [63:0] e_rdata[int];
   bit          e_err[int];
   bit          e_stray[int];
   int          stray_model = 0;
   logic [8:0]  tid_model = '0;
   bit          model_on = 1'b0;

   logic [63:0] regs[logic [15:0]];
   bit          p_wrong[int];

   bit          pin_res_en = 0, pin_rerr = 0, pin_stray_en = 0, pin_tid_en = 0;
   logic [63:0] pin_rdata = '0;
   logic [15:0] pin_stray = '0;
   logic [8:0]  pin_tid = '0;

   function automatic logic [63:0] afu_val(input logic [15:0] a);
      if (regs.exists(a)) return regs[a];
      if (a == 16'h0000) return 64'h1000_0100_0000_0000;
      return {32'hC0DE_0000, 16'h0, a};
   endfunction

   always @(negedge clk) begin
      if (model_on && rst_n) begin
         chk("cmd_ready", 64'(cmd_ready), 64'(e_busy.exists(cyc) == 0));
         chk("mmio_wr_valid", 64'(mmio_wr_valid), 64'(e_wr.exists(cyc)));
         chk("mmio_rd_valid", 64'(mmio_rd_valid), 64'(e_rd.exists(cyc)));
         if (e_wr.exists(cyc) || e_rd.exists(cyc)) begin
            chk("mmio_addr", 64'(mmio_addr), 64'(e_addr[cyc]));
            chk("mmio_tid", 64'(mmio_tid), 64'(e_tid[cyc]));
            chk("mmio_data", mmio_data, e_mdata[cyc]);
         end
         chk("res_valid", 64'(res_valid), 64'(e_res.exists(cyc)));
         if (e_res.exists(cyc)) begin
            chk("res_data", res_data, e_rdata[cyc]);
            chk("res_err", 64'(res_err), 64'(e_err[cyc]));
         end
         chk("stray_cnt", 64'(stray_cnt), 64'(stray_model));
         if (e_stray.exists(cyc) && stray_model < 65535) stray_model++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      e_busy.delete(); e_wr.delete(); e_rd.delete(); e_addr.delete(); e_tid.delete();
      e_mdata.delete(); e_res.delete(); e_rdata.delete(); e_err.delete(); e_stray.delete();
   endtask

   // Issues one command now; response timing is taken from p_wrong (offset -> wrong TID).
   task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [63:0] wd);
      int t0, done, last, m;
      logic [8:0] itid;
      t0 = cyc;
      m = -1;
      itid = tid_model;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      e_addr[t0+1] = addr;
      e_tid[t0+1] = itid;
      e_busy[t0+1] = 1;
      if (wr) begin
         e_wr[t0+1] = 1;
         e_mdata[t0+1] = wd;
         regs[addr] = wd;
         done = t0 + 2;
      end else begin
         e_rd[t0+1] = 1;
         e_mdata[t0+1] = '0;
         tid_model++;
         foreach (p_wrong[o]) if (m < 0 && !p_wrong[o] && o >= 2 && o <= TO) m = o;
         done = (m >= 0) ? t0 + m + 1 : t0 + 1 + TO;
         e_res[done] = 1;
         e_rdata[done] = (m >= 0) ? afu_val(addr) : 64'h0;
         e_err[done] = (m < 0);
         for (int c = t0 + 2; c < done; c++) e_busy[c] = 1;
      end
      last = done;
      foreach (p_wrong[o]) begin
         if (o != m) e_stray[t0+o] = 1;
         if (t0 + o + 1 > last) last = t0 + o + 1;
      end
      tick();
      cmd_valid = 1'b0;
      while (cyc < last) begin
         rsp_valid = p_wrong.exists(cyc - t0);
         if (rsp_valid) begin
            rsp_tid = p_wrong[cyc-t0] ? (itid ^ 9'h155) : itid;
            rsp_data = p_wrong[cyc-t0] ? {$urandom, $urandom} : afu_val(addr);
         end
         if (pin_tid_en && cyc == t0 + 1) begin
            #3;
            chk("pin_issue_tid", 64'(mmio_tid), 64'(pin_tid));
         end
         tick();
      end
      rsp_valid = 1'b0;
      if (pin_res_en && cyc == done) begin
         #3;
         chk("pin_res_data", res_data, pin_rdata);
         chk("pin_res_err", 64'(res_err), 64'(pin_rerr));
         chk("pin_res_valid", 64'(res_valid), 64'h1);
         if (pin_stray_en) chk("pin_stray", 64'(stray_cnt), 64'(pin_stray));
      end
      pin_res_en = 0; pin_stray_en = 0; pin_tid_en = 0;
      p_wrong.delete();
   endtask

   task automatic idle(input int n, input bit stray);
      for (int i = 0; i < n; i++) begin
         rsp_valid = stray;
         rsp_tid = 9'($urandom);
         if (stray) e_stray[cyc] = 1;
         tick();
      end
      rsp_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, mode, off;
      logic [8:0] itid;
      repeat (3) tick();
      rst_n = 1'b1;
      model_on = 1'b1;
      #3;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
      chk("rst_mmio_addr", 64'(mmio_addr), 64'h0);
      chk("rst_mmio_tid", 64'(mmio_tid), 64'h0);
      chk("rst_mmio_data", mmio_data, 64'h0);
      chk("rst_res_data", res_data, 64'h0);
      chk("rst_res_err", 64'(res_err), 64'h0);
      tick();

      // DFH read, one-cycle AFU latency.
      p_wrong[2] = 0;
      pin_tid_en = 1; pin_tid = 9'd0;
      pin_res_en = 1; pin_rdata = 64'h1000_0100_0000_0000; pin_rerr = 0;
      run_cmd(0, 16'h0000, '0);
      // Posted write then read-back; write must not consume a TID.
      pin_tid_en = 1; pin_tid = 9'd1;
      run_cmd(1, 16'h0020, 64'hDEAD_BEEF_0123_4567);
      p_wrong[2] = 0;
      pin_tid_en = 1; pin_tid = 9'd1;
      pin_res_en = 1; pin_rdata = 64'hDEAD_BEEF_0123_4567; pin_rerr = 0;
      run_cmd(0, 16'h0020, '0);
      // Silent AFU: timeout.
      pin_res_en = 1; pin_rdata = 64'h0; pin_rerr = 1;
      run_cmd(0, 16'h0028, '0);
      // Wrong TID, then correct TID two cycles later.
      p_wrong[2] = 1; p_wrong[4] = 0;
      pin_res_en = 1; pin_rdata = 64'hDEAD_BEEF_0123_4567; pin_rerr = 0;
      pin_stray_en = 1; pin_stray = 16'd1;
      run_cmd(0, 16'h0020, '0);
      // Match on the last waiting cycle wins over timeout.
      p_wrong[TO] = 0;
      pin_res_en = 1; pin_rdata = 64'h1000_0100_0000_0000; pin_rerr = 0;
      run_cmd(0, 16'h0000, '0);
      // One cycle too late: timeout, then a stray.
      p_wrong[TO+1] = 0;
      run_cmd(0, 16'h0030, '0);
      idle(2, 0);

      // Reset while waiting; the late response is a stray.
      t0 = cyc;
      itid = tid_model;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
      e_rd[t0+1] = 1; e_addr[t0+1] = 16'h0020; e_tid[t0+1] = itid; e_mdata[t0+1] = '0;
      for (int c = t0 + 1; c <= t0 + 3; c++) e_busy[c] = 1;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      clear_model();
      repeat (2) tick();
      rst_n = 1'b1;
      stray_model = 0;
      tid_model = '0;
      tick();
      rsp_valid = 1'b1; rsp_tid = itid; rsp_data = 64'h1234;
      e_stray[cyc] = 1;
      tick();
      rsp_valid = 1'b0;
      #3;
      chk("rstw_stray", 64'(stray_cnt), 64'h1);
      chk("rstw_res_valid", 64'(res_valid), 64'h0);
      chk("rstw_cmd_ready", 64'(cmd_ready), 64'h1);
      tick();

      // 513 back-to-back reads walk the whole TID space and wrap.
      for (int i = 0; i < 513; i++) begin
         p_wrong[2] = 0;
         if (i == 0 || i == 511 || i == 512) begin
            pin_tid_en = 1;
            pin_tid = (i == 511) ? 9'd511 : 9'd0;
         end
         run_cmd(0, 16'(($urandom % 9) * 8), '0);
      end

      // Random mix of writes, reads and response behaviours.
      for (int i = 0; i < 150; i++) begin
         if ($urandom % 4 == 0) p_wrong[1] = 1;
         if ($urandom % 3 == 0) begin
            run_cmd(1, 16'(($urandom % 9) * 8), {$urandom, $urandom});
         end else begin
            mode = $urandom % 6;
            case (mode)
               0: ;
               1: p_wrong[$urandom_range(2, TO)] = 0;
               2: begin
                  off = $urandom_range(2, 6);
                  p_wrong[off] = 1;
                  p_wrong[off + $urandom_range(1, 4)] = 0;
               end
               3: p_wrong[$urandom_range(TO + 1, TO + 3)] = 0;
               default: p_wrong[$urandom_range(2, 4)] = 0;
            endcase
            run_cmd(0, 16'(($urandom % 9) * 8), '0);
         end
         idle($urandom % 3, ($urandom % 5) == 0);
      end
      idle(2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
